// File: rtl/nexys4ddr_uart_rx_if.sv
// nexys4ddr_uart_rx_if: received-byte valid/ready stream plus error pulses
interface nexys4ddr_uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
    modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/nexys4ddr_uart_rx.sv
// nexys4ddr_uart_rx: 8N1 UART receiver feeding a small FIFO on a valid/ready stream
module nexys4ddr_uart_rx #(
    parameter int FREQ       = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                cpu_reset_n,
    input  logic                uart_txd_in,
    nexys4ddr_uart_rx_if.master rx
);
    localparam int DIV  = FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state, state_d;
    logic [1:0]    sync;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          tick, load_half, load_div, shift, push_req, ferr_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, pop, push;

    assign rxs  = sync[1];
    assign tick = cnt == '0;

    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) sync <= 2'b11;
        else sync <= {sync[0], uart_txd_in};
    end

    always_comb begin
        state_d   = state;
        load_half = 1'b0;
        load_div  = 1'b0;
        shift     = 1'b0;
        push_req  = 1'b0;
        ferr_d    = 1'b0;
        case (state)
            IDLE: if (!rxs) begin
                state_d   = START;
                load_half = 1'b1;
            end
            START: if (tick) begin
                state_d  = rxs ? IDLE : DATA;
                load_div = !rxs;
            end
            DATA: if (tick) begin
                shift    = 1'b1;
                load_div = 1'b1;
                state_d  = idx == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick) begin
                state_d  = rxs ? IDLE : BREAK;
                push_req = rxs;
                ferr_d   = !rxs;
            end
            BREAK: if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_d;
            cnt   <= load_half ? CW'(HALF - 1) : load_div ? CW'(DIV - 1) : cnt - CW'(1);
            idx   <= state == DATA ? idx + 3'(shift) : 3'd0;
            shreg <= shift ? {rxs, shreg[7:1]} : shreg;
        end
    end

    // A push into a full FIFO is still accepted when the head is popped the same cycle
    assign full         = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign rx.rx_valid  = wr_ptr != rd_ptr;
    assign pop          = rx.rx_valid && rx.rx_ready;
    assign push         = push_req && (!full || pop);
    assign rx.rx_data   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rx.frame_err <= 1'b0;
            rx.overrun   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) mem[wr_ptr[AW-1:0]] <= shreg;
            wr_ptr       <= wr_ptr + (AW+1)'(push);
            rd_ptr       <= rd_ptr + (AW+1)'(pop);
            rx.frame_err <= ferr_d;
            rx.overrun   <= push_req && full && !pop;
        end
    end
endmodule

// File: tb/tb_nexys4ddr_uart_rx.sv
// tb_nexys4ddr_uart_rx: directed 8N1 frames against the UART receiver at a 33-cycle bit period
module tb_nexys4ddr_uart_rx;
    localparam int DIV  = 33;
    localparam int HALF = 16;
    localparam int LAT  = 3 + HALF + 9 * DIV;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_pops;
        logic [7:0] exp_byte;
        int         exp_ferr;
    } vec_t;

    logic clk = 1'b0;
    logic cpu_reset_n = 1'b0;
    logic uart_txd_in = 1'b1;
    int   tests = 0, fails = 0, cyc = 0;
    int   n_ferr = 0, n_ovr = 0, n_rise = 0, rise_cyc = 0, ferr_cyc = 0, ovr_cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] popped[$];
    vec_t vecs[5];
    int   t0, np, nf, no, nr;

    always #5 clk = ~clk;

    nexys4ddr_uart_rx_if u_if();

    nexys4ddr_uart_rx #(.FREQ(100000000), .BAUD(3000000), .FIFO_DEPTH(4)) u_dut (
        .clk(clk),
        .cpu_reset_n(cpu_reset_n),
        .uart_txd_in(uart_txd_in),
        .rx(u_if)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.rx_valid && !prev_valid) begin n_rise++; rise_cyc = cyc; end
        if (u_if.frame_err) begin n_ferr++; ferr_cyc = cyc; end
        if (u_if.overrun) begin n_ovr++; ovr_cyc = cyc; end
        if (u_if.rx_valid && u_if.rx_ready) popped.push_back(u_if.rx_data);
        prev_valid = u_if.rx_valid;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, output int c0);
        c0 = cyc;
        uart_txd_in = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_txd_in = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_txd_in = stop;
        repeat (DIV) @(negedge clk);
        uart_txd_in = 1'b1;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, " valid"}, int'(u_if.rx_valid), 1);
        check({name, " data"}, int'(u_if.rx_data), int'(exp));
        u_if.rx_ready = 1'b1;
        @(negedge clk);
        u_if.rx_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1, 8'h55, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[3] = '{8'h81, 1'b1, 1, 8'h81, 0};
        vecs[4] = '{8'hC3, 1'b0, 0, 8'h00, 1};
        u_if.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset rx_valid", int'(u_if.rx_valid), 0);
        check("reset rx_data", int'(u_if.rx_data), 0);
        check("reset frame_err", int'(u_if.frame_err), 0);
        check("reset overrun", int'(u_if.overrun), 0);
        cpu_reset_n = 1'b1;
        repeat (5) @(negedge clk);

        u_if.rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            np = popped.size();
            nf = n_ferr;
            send_byte(vecs[i].data, vecs[i].stop, t0);
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d pops", i), popped.size() - np, vecs[i].exp_pops);
            check($sformatf("vec%0d ferr", i), n_ferr - nf, vecs[i].exp_ferr);
            if (vecs[i].exp_pops != 0) begin
                check($sformatf("vec%0d byte", i), popped.size() > np ? int'(popped[$]) : -1, int'(vecs[i].exp_byte));
                check($sformatf("vec%0d valid latency", i), rise_cyc - t0, LAT);
            end
            if (vecs[i].exp_ferr != 0) check($sformatf("vec%0d ferr latency", i), ferr_cyc - t0, LAT);
        end
        check("table overrun", n_ovr, 0);

        u_if.rx_ready = 1'b0;
        nr = n_rise;
        send_byte(8'hA5, 1'b1, t0);
        send_byte(8'h3C, 1'b1, t0);
        send_byte(8'hFF, 1'b1, t0);
        repeat (10) @(negedge clk);
        check("b2b single rise", n_rise - nr, 1);
        pop_check("b2b 0", 8'hA5);
        pop_check("b2b 1", 8'h3C);
        pop_check("b2b 2", 8'hFF);
        check("b2b drained", int'(u_if.rx_valid), 0);

        u_if.rx_ready = 1'b1;
        np = popped.size();
        nf = n_ferr;
        send_byte(8'h81, 1'b0, t0);
        uart_txd_in = 1'b0;
        repeat (20 * DIV) @(negedge clk);
        check("break ferr pulses", n_ferr - nf, 1);
        check("break no push", popped.size() - np, 0);
        check("break valid", int'(u_if.rx_valid), 0);
        uart_txd_in = 1'b1;
        repeat (10) @(negedge clk);
        send_byte(8'h42, 1'b1, t0);
        repeat (20) @(negedge clk);
        check("after break pops", popped.size() - np, 1);
        check("after break byte", popped.size() > np ? int'(popped[$]) : -1, 8'h42);

        nr = n_rise;
        nf = n_ferr;
        uart_txd_in = 1'b0;
        repeat (8) @(negedge clk);
        uart_txd_in = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch no valid", n_rise - nr, 0);
        check("glitch no ferr", n_ferr - nf, 0);

        u_if.rx_ready = 1'b0;
        no = n_ovr;
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1, t0);
        repeat (10) @(negedge clk);
        check("overrun pulses", n_ovr - no, 1);
        check("overrun latency", ovr_cyc - t0, LAT);
        for (int b = 1; b <= 4; b++) pop_check($sformatf("ovr pop%0d", b), 8'(b));
        check("ovr drained", int'(u_if.rx_valid), 0);

        for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b1, t0);
        no = n_ovr;
        fork
            send_byte(8'h05, 1'b1, t0);
            begin
                repeat (LAT - 1) @(negedge clk);
                u_if.rx_ready = 1'b1;
                @(negedge clk);
                u_if.rx_ready = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        check("full push+pop overrun", n_ovr - no, 0);
        for (int b = 2; b <= 5; b++) pop_check($sformatf("full pop%0d", b), 8'(b));
        check("full drained", int'(u_if.rx_valid), 0);

        send_byte(8'h11, 1'b1, t0);
        send_byte(8'h22, 1'b1, t0);
        check("pre-reset valid", int'(u_if.rx_valid), 1);
        fork
            send_byte(8'hF0, 1'b1, t0);
            begin
                repeat (4 * DIV + HALF) @(negedge clk);
                cpu_reset_n = 1'b0;
                #1;
                check("mid reset valid", int'(u_if.rx_valid), 0);
                check("mid reset data", int'(u_if.rx_data), 0);
            end
        join
        repeat (10) @(negedge clk);
        cpu_reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post reset valid", int'(u_if.rx_valid), 0);
        u_if.rx_ready = 1'b1;
        np = popped.size();
        send_byte(8'h7E, 1'b1, t0);
        repeat (20) @(negedge clk);
        check("post reset pops", popped.size() - np, 1);
        check("post reset byte", popped.size() > np ? int'(popped[$]) : -1, 8'h7E);
        check("post reset latency", rise_cyc - t0, LAT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
